// File: rtl/store_buffer_if.sv
// Memory-stage side and dmem side of the store buffer, bundled into one interface.
// master: pipeline/dmem environment, slave: the buffer itself.
interface store_buffer_if;
  // Memory-stage request
  logic        memwriteM;
  logic        sbM;
  logic        memreadM;
  logic [31:0] dataadrM;
  logic [31:0] writedataM;
  // Memory-stage response
  logic        stallM;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  // Drain port toward dmem
  logic        dm_we;
  logic        dm_sb;
  logic [31:0] dm_adr;
  logic [31:0] dm_wd;
  logic        dm_ready;
  // Status
  logic        sb_empty;

  modport master (
    output memwriteM, sbM, memreadM, dataadrM, writedataM, dm_ready,
    input  stallM, fwd_hit, fwd_data, dm_we, dm_sb, dm_adr, dm_wd, sb_empty
  );

  modport slave (
    input  memwriteM, sbM, memreadM, dataadrM, writedataM, dm_ready,
    output stallM, fwd_hit, fwd_data, dm_we, dm_sb, dm_adr, dm_wd, sb_empty
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store buffer: accepts word/byte stores in one cycle, drains them in order
// to dmem over a ready/valid handshake, and forwards or stalls loads hitting pending stores.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  store_buffer_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  ptr_t        wr_ptr;
  ptr_t        rd_ptr;
  cnt_t        count;

  logic [31:0] adr_q  [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [DEPTH-1:0] sb_q;

  logic        full;
  logic        empty;
  logic        push;
  logic        pop;

  logic        found;
  logic        found_sb;
  logic [31:0] found_data;
  logic        hit;
  logic        conflict;

  assign full  = (count == cnt_t'(DEPTH));
  assign empty = (count == '0);
  // A full buffer refuses the push even if the head drains this very edge.
  assign push  = bus.memwriteM & ~full;
  assign pop   = ~empty & bus.dm_ready;

  // Pointer and occupancy state; reset discards every pending store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      unique case ({push, pop})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload; contents are meaningless while the slot is not counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      adr_q[wr_ptr]  <= bus.dataadrM;
      data_q[wr_ptr] <= bus.writedataM;
      sb_q[wr_ptr]   <= bus.sbM;
    end
  end

  // Load lookup: walk entries oldest to youngest so the youngest word-address match wins.
  always_comb begin
    ptr_t idx;
    idx        = '0;
    found      = 1'b0;
    found_sb   = 1'b0;
    found_data = '0;
    // A simultaneous store+load is treated as a store only.
    if (bus.memreadM && !bus.memwriteM) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        idx = rd_ptr + ptr_t'(i);
        if ((cnt_t'(i) < count) && (adr_q[idx][31:2] == bus.dataadrM[31:2])) begin
          found      = 1'b1;
          found_sb   = sb_q[idx];
          found_data = data_q[idx];
        end
      end
    end
    // A word store covers all four bytes, so only the youngest match type matters.
    hit      = found & ~found_sb;
    conflict = found & found_sb;
  end

  assign bus.stallM   = (bus.memwriteM & full) | conflict;
  assign bus.fwd_hit  = hit;
  assign bus.fwd_data = hit ? found_data : '0;

  assign bus.dm_we    = ~empty;
  assign bus.dm_sb    = sb_q[rd_ptr];
  assign bus.dm_adr   = adr_q[rd_ptr];
  assign bus.dm_wd    = data_q[rd_ptr];
  assign bus.sb_empty = empty;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference of pending stores.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;

  store_buffer_if bus ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] data;
    logic        sb;
  } ent_t;

  ent_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.memwriteM  = 1'b0;
    bus.sbM        = 1'b0;
    bus.memreadM   = 1'b0;
    bus.dataadrM   = '0;
    bus.writedataM = '0;
  endtask

  // One clock cycle: drive, check at negedge against the model, then advance the model.
  task automatic cycle(input logic wr, input logic sb, input logic rd,
                       input logic [31:0] adr, input logic [31:0] wd,
                       input logic rdy, input string tag, output logic stalled);
    logic        e_hit, e_conf, e_stall, do_push, do_pop, done;
    logic [31:0] e_fd;
    ent_t        e;
    bus.memwriteM  = wr;
    bus.sbM        = sb;
    bus.memreadM   = rd;
    bus.dataadrM   = adr;
    bus.writedataM = wd;
    bus.dm_ready   = rdy;
    @(negedge clk);
    e_hit  = 1'b0;
    e_conf = 1'b0;
    e_fd   = '0;
    done   = 1'b0;
    if (rd && !wr) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (!done && q[i].adr[31:2] == adr[31:2]) begin
          done = 1'b1;
          if (q[i].sb) e_conf = 1'b1;
          else begin
            e_hit = 1'b1;
            e_fd  = q[i].data;
          end
        end
      end
    end
    e_stall = (wr && q.size() == DEPTH) || e_conf;
    chk({tag, "/dm_we"},    32'(bus.dm_we),    32'(q.size() != 0));
    chk({tag, "/sb_empty"}, 32'(bus.sb_empty), 32'(q.size() == 0));
    chk({tag, "/count"},    32'(dut.count),    32'(q.size()));
    chk({tag, "/stallM"},   32'(bus.stallM),   32'(e_stall));
    chk({tag, "/fwd_hit"},  32'(bus.fwd_hit),  32'(e_hit));
    if (e_hit) chk({tag, "/fwd_data"}, bus.fwd_data, e_fd);
    if (q.size() != 0) begin
      chk({tag, "/dm_adr"}, bus.dm_adr,       q[0].adr);
      chk({tag, "/dm_wd"},  bus.dm_wd,        q[0].data);
      chk({tag, "/dm_sb"},  32'(bus.dm_sb),   32'(q[0].sb));
    end
    stalled = e_stall;
    do_push = wr && (q.size() < DEPTH);
    do_pop  = (q.size() != 0) && rdy;
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      e.adr  = adr;
      e.data = wd;
      e.sb   = sb;
      q.push_back(e);
    end
    #1;
  endtask

  initial begin
    logic st;
    logic [31:0] a, d;
    int tries;

    // Reset state
    reset = 1'b1;
    drive_idle();
    bus.memreadM = 1'b1;
    bus.dm_ready = 1'b1;
    #2;
    chk("rst/dm_we",    32'(bus.dm_we),    32'd0);
    chk("rst/sb_empty", 32'(bus.sb_empty), 32'd1);
    chk("rst/stallM",   32'(bus.stallM),   32'd0);
    chk("rst/fwd_hit",  32'(bus.fwd_hit),  32'd0);
    drive_idle();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single word store drains the cycle after push
    cycle(1, 0, 0, 32'h40, 32'hDEADBEEF, 1, "w40", st);
    chk("w40/visible", 32'(q.size()), 32'd1);
    cycle(0, 0, 0, 0, 0, 1, "w40_head", st);
    cycle(0, 0, 0, 0, 0, 1, "w40_after", st);

    // Fill to DEPTH with dmem blocked; fifth store stalls
    for (int k = 0; k < 5; k++)
      cycle(1, 0, 0, 32'h200 + 32'(k * 4), 32'hA000_0000 + 32'(k), 0, "fill", st);
    chk("fill/fifth_stalled", 32'(st), 32'd1);
    tries = 0;
    do begin
      cycle(1, 0, 0, 32'h210, 32'hA000_0004, 1, "held", st);
      tries++;
    end while (st && tries < 10);
    chk("held/accepted", 32'(st), 32'd0);
    for (int k = 0; k < 6; k++) cycle(0, 0, 0, 0, 0, 1, "drain1", st);

    // Word forward
    cycle(1, 0, 0, 32'h80, 32'h11223344, 0, "fw_st", st);
    cycle(0, 0, 1, 32'h82, 0, 0, "fw_ld", st);
    cycle(0, 0, 0, 0, 0, 1, "fw_dr", st);

    // Byte store conflict
    cycle(1, 1, 0, 32'h81, 32'h000000AA, 0, "bc_st", st);
    cycle(0, 0, 1, 32'h80, 0, 0, "bc_ld0", st);
    cycle(0, 0, 1, 32'h80, 0, 0, "bc_ld1", st);
    cycle(0, 0, 1, 32'h80, 0, 1, "bc_pop", st);
    cycle(0, 0, 1, 32'h80, 0, 1, "bc_after", st);
    chk("bc/released", 32'(st), 32'd0);

    // Youngest match wins; word over older byte forwards
    cycle(1, 0, 0, 32'h100, 32'h1, 0, "yw1", st);
    cycle(1, 0, 0, 32'h100, 32'h2, 0, "yw2", st);
    cycle(0, 0, 1, 32'h100, 0, 0, "yw_ld", st);
    cycle(0, 0, 0, 0, 0, 1, "yw_dr0", st);
    cycle(1, 1, 0, 32'h101, 32'h55, 0, "yb", st);
    cycle(0, 0, 1, 32'h103, 0, 0, "yb_ld", st);
    cycle(1, 0, 0, 32'h100, 32'h3, 0, "yw3", st);
    cycle(0, 0, 1, 32'h100, 0, 0, "yw3_ld", st);
    cycle(1, 0, 1, 32'h100, 32'h4, 1, "both", st);

    // Simultaneous push and pop around the wrap; count must hold
    for (int k = 0; k < 10; k++)
      cycle(1, k[0], 0, 32'h400 + 32'(k * 4), 32'hC0DE_0000 + 32'(k), 1, "pp", st);
    for (int k = 0; k < 6; k++) cycle(0, 0, 0, 0, 0, 1, "drain2", st);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      a = 32'h300 + (32'($urandom_range(0, 3)) << 2) + 32'($urandom_range(0, 3));
      d = $urandom;
      cycle(r <= 3 || r == 7, 1'($urandom_range(0, 1)), r >= 4 && r <= 7, a, d,
            $urandom_range(0, 2) != 0, "rnd", st);
    end

    // Async reset with three entries pending
    for (int k = 0; k < 3; k++) cycle(1, 0, 0, 32'h500 + 32'(k * 4), 32'(k), 0, "prerst", st);
    drive_idle();
    bus.memreadM = 1'b1;
    bus.dataadrM = 32'h500;
    #2;
    reset = 1'b1;
    #1;
    chk("mrst/dm_we",    32'(bus.dm_we),    32'd0);
    chk("mrst/sb_empty", 32'(bus.sb_empty), 32'd1);
    chk("mrst/stallM",   32'(bus.stallM),   32'd0);
    chk("mrst/fwd_hit",  32'(bus.fwd_hit),  32'd0);
    q.delete();
    drive_idle();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 5; k++) cycle(0, 0, 1, 32'h504, 0, 1, "postrst", st);
    cycle(1, 0, 0, 32'h600, 32'h77, 1, "postrst_st", st);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 0, 1, "postrst_dr", st);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
